// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) between decode and execute.
// The skid entry absorbs one transfer accepted while downstream stalls, so in_ready can stay registered.
module pipe_skid_reg #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_OPS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OPS*XLEN-1:0] in_ops,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    bubble,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_OPS*XLEN-1:0] out_ops,
    output logic [XLEN-1:0]         out_pc,
    output logic [1:0]              occupancy
);

    localparam int unsigned OPS_W = NUM_OPS * XLEN;

    typedef struct packed {
        logic             valid;
        logic [OPS_W-1:0] ops;
        logic [XLEN-1:0]  pc;
    } entry_t;

    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic [1:0] occ_q, occ_d;
    logic       in_fire;
    logic       out_fire;

    // bubble is the only combinational contributor to in_ready
    assign in_ready = !skid_q.valid && !bubble;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = main_q.valid && out_ready;

    // Next-state: flush wins, then refill main (skid first), otherwise park input in skid
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d       = '{valid: 1'b0, ops: '0, pc: in_pc};
            skid_d.valid = 1'b0;
        end else if (!main_q.valid || out_fire) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_fire) begin
                main_d = '{valid: 1'b1, ops: in_ops, pc: in_pc};
            end else if (bubble) begin
                main_d = '{valid: 1'b0, ops: '0, pc: in_pc};
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = '{valid: 1'b1, ops: in_ops, pc: in_pc};
        end
        occ_d = 2'(main_d.valid) + 2'(skid_d.valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            occ_q  <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = main_q.valid;
    assign out_ops   = main_q.ops;
    assign out_pc    = main_q.pc;
    assign occupancy = occ_q;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the width of each operand field and of the pc.
REQ-002 SHALL have parameter NUM_OPS, default 3, meaning the count of operand fields (rs1 data, rs2 data, sext imme).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream entry is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage accepts the upstream entry.
REQ-007 SHALL have port in_ops, input, NUM_OPS*XLEN bits: packed operands, field i at [i*XLEN +: XLEN].
REQ-008 SHALL have port in_pc, input, XLEN bits: the upstream pc.
REQ-009 SHALL have port bubble, input, 1 bit: insert a bubble; replaces the stall input of earlier generations.
REQ-010 SHALL have port flush, input, 1 bit: kill all entries (jump/branch taken).
REQ-011 SHALL have port out_valid, output, 1 bit: the main entry is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts; low replaces the waiting input of earlier generations.
REQ-013 SHALL have port out_ops, output, NUM_OPS*XLEN bits: main-entry operands.
REQ-014 SHALL have port out_pc, output, XLEN bits: main-entry pc.
REQ-015 SHALL have port occupancy, output, 2 bits: count of valid entries, 0..2.

Function
REQ-016 SHALL hold two entries: main (drives out_*) and skid; each entry is valid bit + ops + pc.
REQ-017 SHALL drive in_ready = !skid_valid && !bubble; the skid_valid term is registered, and bubble is the only combinational path.
REQ-018 SHALL define in_fire = in_valid && in_ready && !flush and out_fire = out_valid && out_ready.
REQ-019 SHALL treat flush as top priority after rst: next cycle main_valid=0, skid_valid=0, out_ops=0, out_pc=in_pc; in_fire data is discarded.
REQ-020 SHALL, when main is empty or out_fire, and skid_valid, move skid to main and clear skid_valid (in_ready=0 that cycle, so no input arrives).
REQ-021 SHALL, when main is empty or out_fire, and skid is empty with in_fire, load main from in_ops/in_pc with main_valid=1.
REQ-022 SHALL, when main is empty or out_fire, skid is empty, and bubble=1, set out_ops=0, out_pc=in_pc, and main_valid=0.
REQ-023 SHALL, when main is empty or out_fire with no skid, no in_fire and no bubble, set main_valid=0 and hold data.
REQ-024 SHALL, when main_valid && !out_ready, hold main unchanged; an in_fire in that cycle loads the skid (skid_valid=1).
REQ-025 SHALL never drop or duplicate a valid entry: order out equals order of in_fire, absent flush.
REQ-026 SHALL drive occupancy = main_valid + skid_valid, and occupancy SHALL never exceed 2.
REQ-027 SHALL yield latency from in_fire to out_valid of 1 cycle when empty, and sustain throughput of 1 entry/cycle while out_ready=1.

Reset
REQ-028 SHALL, on rst high at a clock edge, set main_valid=0, skid_valid=0, out_ops=0, out_pc=0, occupancy=0, irrespective of other inputs.
REQ-029 SHALL, on rst mid-transfer, discard both entries; the first cycle after rst deasserts gives in_ready=1 (if bubble=0).

Verification
REQ-030 SHALL pass streaming: pc 0x100,0x104,0x108 with in_valid=1, out_ready=1 -> out_pc 0x100,0x104,0x108 on consecutive cycles, each 1 cycle after input, occupancy=1.
REQ-031 SHALL pass backpressure: out_ready=0 while sending pc 0x200 then 0x204 -> main=0x200, skid=0x204, occupancy=2, in_ready=0; raising out_ready gives 0x200 then 0x204, no loss.
REQ-032 SHALL pass flush with occupancy 2: flush=1, in_pc=0x300 -> next cycle out_valid=0, out_ops=0, out_pc=0x300, occupancy=0.
REQ-033 SHALL pass bubble: main empty, bubble=1, in_valid=1, in_pc=0x400 -> in_ready=0 the same cycle; next cycle out_valid=0, out_ops=0, out_pc=0x400.
REQ-034 SHALL pass reset during backpressure: occupancy=2, rst=1 one cycle -> all outputs 0; following cycle in_ready=1.
REQ-035 SHALL pass parameter sweep: XLEN=32, NUM_OPS=3 and XLEN=64, NUM_OPS=4 with random valid/ready/bubble/flush -> scoreboard shows in-order, lossless delivery.
